// File: rtl/ram128x1_byte_arbiter.sv
// Byte-wide, two-port round-robin access controller for a 128x1 RAM.
// Each byte access runs as 8 single-bit RAM cycles, LSB first.
module ram128x1_byte_arbiter #(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [3:0] addr0,
  input  logic [3:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       ready,
  output logic [6:0] ram_addr,
  output logic       ram_d,
  output logic       ram_we,
  input  logic       ram_o
);

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    XFER,
    DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [6:0] cnt;
  logic [2:0] bitk;
  logic [2:0] bit_nxt;
  logic       last_grant;
  logic       gnt;
  logic       l_we;
  logic [3:0] l_addr;
  logic [7:0] l_wdata;
  logic       any_req;
  logic       pick1;
  logic       clear_done;
  logic       last_bit;
  logic       we_sel;
  logic [3:0] addr_sel;
  logic [7:0] wdata_sel;

  // Tie goes to the port that did not win the previous tie.
  assign any_req    = req0 | req1;
  assign pick1      = req1 & (~req0 | ~last_grant);
  assign we_sel     = pick1 ? we1 : we0;
  assign addr_sel   = pick1 ? addr1 : addr0;
  assign wdata_sel  = pick1 ? wdata1 : wdata0;
  assign clear_done = ram_we & (ram_addr == 7'd127);
  assign last_bit   = (bitk == 3'd7);
  assign bit_nxt    = bitk + 3'd1;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if (CLEAR_ON_RESET) state <= CLEAR;
      else                state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      CLEAR: if (clear_done) state_nxt = IDLE;
      IDLE:  if (any_req)    state_nxt = XFER;
      XFER:  if (last_bit)   state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs, sweep counter, grant latch and bit sequencer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr   <= '0;
      ram_d      <= 1'b0;
      ram_we     <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata      <= '0;
      ready      <= ~CLEAR_ON_RESET;
      cnt        <= '0;
      bitk       <= '0;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      l_we       <= 1'b0;
      l_addr     <= '0;
      l_wdata    <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          if (clear_done) begin
            ram_we <= 1'b0;
            ready  <= 1'b1;
          end else begin
            ram_we   <= 1'b1;
            ram_d    <= 1'b0;
            ram_addr <= cnt;
            cnt      <= cnt + 7'd1;
          end
        end
        IDLE: begin
          if (any_req) begin
            gnt      <= pick1;
            if (req0 & req1) last_grant <= pick1;
            l_we     <= we_sel;
            l_addr   <= addr_sel;
            l_wdata  <= wdata_sel;
            bitk     <= 3'd0;
            ram_addr <= {addr_sel, 3'd0};
            ram_we   <= we_sel;
            ram_d    <= wdata_sel[0];
          end
        end
        XFER: begin
          if (!l_we) rdata[bitk] <= ram_o;
          if (last_bit) begin
            ram_we <= 1'b0;
            ack0   <= ~gnt;
            ack1   <= gnt;
          end else begin
            bitk     <= bit_nxt;
            ram_addr <= {l_addr, bit_nxt};
            ram_d    <= l_wdata[bit_nxt];
          end
        end
        DONE: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram128x1_byte_arbiter.sv
// Bench for ram128x1_byte_arbiter: RAM model, byte-level reference
// memory and round-robin tie model, directed plus random accesses.
module tb_ram128x1_byte_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic       we0 = 1'b0, we1 = 1'b0;
  logic [3:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       ack0, ack1;
  logic [7:0] rdata;
  logic       ready;
  logic [6:0] ram_addr;
  logic       ram_d;
  logic       ram_we;
  logic       ram_o;

  ram128x1_byte_arbiter #(.CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1),
    .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .ready(ready),
    .ram_addr(ram_addr), .ram_d(ram_d),
    .ram_we(ram_we), .ram_o(ram_o)
  );

  always #5 clk = ~clk;

  logic [127:0] mem;
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_d;
  assign ram_o = mem[ram_addr];

  int         checks = 0;
  int         errors = 0;
  logic [7:0] ref_mem [16];
  bit         last_g;
  int         e0, e1, ovl;
  logic [7:0] rd0, rd1;
  logic [6:0] tr_addr [64];
  logic       tr_d [64];
  logic       tr_we [64];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input bit pend1, input logic [3:0] a1);
    int bad;
    reset_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_ack", 32'({ack0, ack1}), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_d", 32'(ram_d), 0);
    reset_n = 1'b1;
    if (pend1) begin
      we1 = 1'b0;
      addr1 = a1;
      req1 = 1'b1;
    end
    bad = 0;
    for (int e = 1; e <= 129; e++) begin
      @(posedge clk);
      #1;
      if (ack0 !== 1'b0 || ack1 !== 1'b0) bad++;
      if (e <= 128) begin
        if (!(ram_we === 1'b1 && ram_addr === 7'(e - 1) &&
              ram_d === 1'b0 && ready === 1'b0)) bad++;
      end else if (!(ram_we === 1'b0 && ready === 1'b1)) begin
        bad++;
      end
    end
    chk("sweep", 32'(bad), 0);
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    last_g = 1'b1;
  endtask

  // Runs edges until every raised request has been acked.
  task automatic serve();
    e0 = -1;
    e1 = -1;
    ovl = 0;
    rd0 = '0;
    rd1 = '0;
    for (int e = 1; e <= 40 && (req0 === 1'b1 || req1 === 1'b1); e++) begin
      @(posedge clk);
      #1;
      tr_addr[e] = ram_addr;
      tr_d[e] = ram_d;
      tr_we[e] = ram_we;
      if (ack0 === 1'b1 && ack1 === 1'b1) ovl++;
      if (ack0 === 1'b1) begin e0 = e; rd0 = rdata; end
      if (ack1 === 1'b1) begin e1 = e; rd1 = rdata; end
      @(negedge clk);
      if (ack0 === 1'b1) req0 = 1'b0;
      if (ack1 === 1'b1) req1 = 1'b0;
    end
    chk("no_overlap", 32'(ovl), 0);
    chk("ack_timeout", 32'({req0, req1}), 0);
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk);
    #1;
    chk("ack_clear", 32'({ack0, ack1}), 0);
  endtask

  task automatic check_trace(input int base, input bit w,
                             input logic [3:0] a, input logic [7:0] d);
    int bad;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (tr_addr[base + k] !== {a, 3'(k)}) bad++;
      if (tr_we[base + k] !== w) bad++;
      if (w && tr_d[base + k] !== d[k]) bad++;
    end
    if (tr_we[base + 8] !== 1'b0) bad++;
    chk("bit_trace", 32'(bad), 0);
  endtask

  task automatic access(input int p, input bit w, input logic [3:0] a,
                        input logic [7:0] d);
    logic [7:0] exp;
    exp = ref_mem[a];
    @(negedge clk);
    if (p == 0) begin
      we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1;
    end else begin
      we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1;
    end
    serve();
    chk("ack_edge", p == 0 ? e0 : e1, 9);
    chk("other_ack", p == 0 ? e1 : e0, -1);
    check_trace(1, w, a, d);
    if (w) ref_mem[a] = d;
    else chk("rdata", 32'(p == 0 ? rd0 : rd1), 32'(exp));
  endtask

  task automatic tie(input bit w0, input logic [3:0] a0, input logic [7:0] d0,
                     input bit w1, input logic [3:0] a1, input logic [7:0] d1);
    bit         w [2];
    logic [3:0] a [2];
    logic [7:0] d [2];
    int         ed [2];
    logic [7:0] rd [2];
    int         win, p, base;
    w[0] = w0; a[0] = a0; d[0] = d0;
    w[1] = w1; a[1] = a1; d[1] = d1;
    win = last_g ? 0 : 1;
    @(negedge clk);
    we0 = w0; addr0 = a0; wdata0 = d0; req0 = 1'b1;
    we1 = w1; addr1 = a1; wdata1 = d1; req1 = 1'b1;
    serve();
    ed[0] = e0; ed[1] = e1;
    rd[0] = rd0; rd[1] = rd1;
    for (int j = 0; j < 2; j++) begin
      p = (j == 0) ? win : 1 - win;
      base = (j == 0) ? 1 : 11;
      chk(j == 0 ? "tie_first_ack" : "tie_second_ack", ed[p], base + 8);
      check_trace(base, w[p], a[p], d[p]);
      if (w[p]) ref_mem[a[p]] = d[p];
      else chk("tie_rdata", 32'(rd[p]), 32'(ref_mem[a[p]]));
    end
    last_g = win[0];
  endtask

  initial begin
    do_reset(1'b0, 4'd0);
    access(0, 1'b0, 4'd5, 8'h00);
    access(1, 1'b0, 4'd9, 8'h00);

    access(0, 1'b1, 4'd3, 8'hA5);
    access(0, 1'b0, 4'd3, 8'h00);

    for (int i = 0; i < 3; i++)
      tie(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          8'($urandom),
          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          8'($urandom));

    access(1, 1'b1, 4'd15, 8'h3C);
    access(0, 1'b1, 4'd0, 8'hFF);
    access(0, 1'b0, 4'd15, 8'h00);
    access(1, 1'b0, 4'd0, 8'h00);
    access(0, 1'b0, 4'd14, 8'h00);
    access(1, 1'b0, 4'd1, 8'h00);

    do_reset(1'b1, 4'd15);
    serve();
    chk("pend_ack1_edge", e1, 9);
    chk("pend_ack0", e0, -1);
    chk("pend_rdata", 32'(rd1), 0);
    check_trace(1, 1'b0, 4'd15, 8'h00);

    @(negedge clk);
    we0 = 1'b1; addr0 = 4'd6; wdata0 = 8'hFF; req0 = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pre_abort_addr", 32'(ram_addr), 32'({4'd6, 3'd4}));
    chk("pre_abort_we", 32'(ram_we), 1);
    reset_n = 1'b0;
    req0 = 1'b0;
    #1;
    chk("abort_we", 32'(ram_we), 0);
    chk("abort_ack", 32'({ack0, ack1}), 0);
    chk("abort_ready", 32'(ready), 0);
    do_reset(1'b0, 4'd0);
    access(0, 1'b0, 4'd6, 8'h00);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0)
        tie(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            8'($urandom),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            8'($urandom));
      else
        access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
